// File: rtl/alu_muldiv_seq.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One radix-2 step per cycle on operand magnitudes; signs are restored at commit.
module alu_muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_div_zero
);
    // state    | meaning
    // S_IDLE   | waiting for Start; MTHI/MTLO complete here directly
    // S_CALC   | one shift-add / restoring-divide step per cycle, WIDTH steps
    // S_FINISH | Done cycle after the commit; Start is ignored
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    localparam int            CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MADD  = 3'b100;
    localparam logic [2:0] OP_MSUB  = 3'b101;
    localparam logic [2:0] OP_MTHI  = 3'b110;
    localparam logic [2:0] OP_MTLO  = 3'b111;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic               r_b_zero;
    logic               r_neg_res;
    logic               r_neg_a;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_hw;
    logic [WIDTH-1:0]   r_lw;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;
    logic               r_div_zero;

    logic               w_accept;
    logic               w_is_mt;
    logic               w_signed_in;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_is_div_in;
    logic               w_is_div;
    logic               w_last;
    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_trial;
    logic               w_div_ok;
    logic [WIDTH-1:0]   w_step_hw;
    logic [WIDTH-1:0]   w_step_lw;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_sprod;
    logic [2*WIDTH-1:0] w_commit;

    assign w_accept    = (r_state == S_IDLE) && i_start;
    assign w_is_mt     = (i_op == OP_MTHI) || (i_op == OP_MTLO);
    assign w_signed_in = (i_op == OP_MULT) || (i_op == OP_DIV) ||
                         (i_op == OP_MADD) || (i_op == OP_MSUB);
    assign w_is_div_in = (i_op == OP_DIV) || (i_op == OP_DIVU);
    assign w_a_neg     = w_signed_in && i_a[WIDTH-1];
    assign w_b_neg     = w_signed_in && i_b[WIDTH-1];
    assign w_a_mag     = w_a_neg ? -i_a : i_a;
    assign w_b_mag     = w_b_neg ? -i_b : i_b;

    assign w_is_div = (r_op == OP_DIV) || (r_op == OP_DIVU);
    assign w_last   = (r_cnt == '0);

    // Multiply: {r_hw, r_lw} is the partial product with the multiplier shifting out of r_lw.
    assign w_addend  = r_lw[0] ? r_mcand : '0;
    assign w_mul_sum = {1'b0, r_hw} + {1'b0, w_addend};

    // Divide: r_hw is the partial remainder, r_lw shifts dividend bits out and quotient bits in.
    assign w_div_trial = {r_hw, r_lw[WIDTH-1]} - {1'b0, r_mcand};
    assign w_div_ok    = ~w_div_trial[WIDTH];

    always_comb begin
        w_step_hw = w_mul_sum[WIDTH:1];
        w_step_lw = {w_mul_sum[0], r_lw[WIDTH-1:1]};
        if (w_is_div) begin
            w_step_hw = w_div_ok ? w_div_trial[WIDTH-1:0] : {r_hw[WIDTH-2:0], r_lw[WIDTH-1]};
            w_step_lw = {r_lw[WIDTH-2:0], w_div_ok};
        end
    end

    assign w_prod  = {w_step_hw, w_step_lw};
    assign w_sprod = r_neg_res ? -w_prod : w_prod;

    always_comb begin
        w_commit = w_prod;
        case (r_op)
            OP_MULT:  w_commit = w_sprod;
            OP_MULTU: w_commit = w_prod;
            OP_MADD:  w_commit = {r_hi, r_lo} + w_sprod;
            OP_MSUB:  w_commit = {r_hi, r_lo} - w_sprod;
            OP_DIV: begin
                if (r_b_zero) begin
                    w_commit = {r_a, {WIDTH{1'b1}}};
                end else begin
                    w_commit = {(r_neg_a ? -w_step_hw : w_step_hw),
                                (r_neg_res ? -w_step_lw : w_step_lw)};
                end
            end
            OP_DIVU: begin
                if (r_b_zero) begin
                    w_commit = {r_a, {WIDTH{1'b1}}};
                end else begin
                    w_commit = {w_step_hw, w_step_lw};
                end
            end
            default:  w_commit = w_prod;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_accept && !w_is_mt) w_state_nxt = S_CALC;
            S_CALC:   if (w_last) w_state_nxt = S_FINISH;
            S_FINISH: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_op       <= '0;
            r_a        <= '0;
            r_b_zero   <= 1'b0;
            r_neg_res  <= 1'b0;
            r_neg_a    <= 1'b0;
            r_mcand    <= '0;
            r_hw       <= '0;
            r_lw       <= '0;
            r_cnt      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (i_op == OP_MTHI) begin
                            r_hi   <= i_a;
                            r_done <= 1'b1;
                        end else if (i_op == OP_MTLO) begin
                            r_lo   <= i_a;
                            r_done <= 1'b1;
                        end else begin
                            r_op      <= i_op;
                            r_a       <= i_a;
                            r_b_zero  <= (i_b == '0);
                            r_neg_res <= w_a_neg ^ w_b_neg;
                            r_neg_a   <= w_a_neg;
                            r_mcand   <= w_is_div_in ? w_b_mag : w_a_mag;
                            r_hw      <= '0;
                            r_lw      <= w_is_div_in ? w_a_mag : w_b_mag;
                            r_cnt     <= LAST_STEP;
                            r_busy    <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    r_hw  <= w_step_hw;
                    r_lw  <= w_step_lw;
                    r_cnt <= r_cnt - 1'b1;
                    // The final step's result is committed directly so Hi/Lo appear with Done.
                    if (w_last) begin
                        r_hi       <= w_commit[2*WIDTH-1:WIDTH];
                        r_lo       <= w_commit[WIDTH-1:0];
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_div_zero <= w_is_div && r_b_zero;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_hi       = r_hi;
    assign o_lo       = r_lo;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_div_zero = r_div_zero;
endmodule
